// File: rtl/uart3_pkg.sv
// Shared definitions for the uart3 receiver: parity modes, FSM states and
// the NCO increment calculation.
package uart3_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // NCO increment: round(baud * 16 * 2^acc_w / clk_freq)
  function automatic longint unsigned calc_inc(input longint unsigned baud,
                                               input longint unsigned clk_freq,
                                               input int unsigned     acc_w);
    return (baud * 64'd16 * (64'd1 << acc_w) + clk_freq / 64'd2) / clk_freq;
  endfunction

endpackage

// File: rtl/uart3_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a sticky
// overflow flag. A push into a full FIFO is accepted only if a pop happens in
// the same cycle; a pop of an empty FIFO is ignored.
module uart3_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         clr_ovf_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  // Accept/ignore decisions, next occupancy and next overflow flag
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and a latch is never inferred.
    count_d = count_q;
    ovf_d   = ovf_q;
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    if (push_i && full_o && !pop_i) begin
      ovf_d = 1'b1;
    end
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: the storage has no reset; entries are only visible once written, and rdata_o is forced to 0 while empty.
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart3_rx.sv
// 16x oversampled UART receiver with NCO bit clock, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, break detection and a receive FIFO.
module uart3_rx
  import uart3_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned BAUD       = 460800,
  parameter int unsigned CLK_FREQ   = 40000000,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_enable,
  input  logic                              rx_in,
  input  logic [1:0]                        cfg_parity,
  input  logic                              rd_en,
  input  logic                              clr_overflow,
  output logic [DATA_BITS+1:0]              rd_data,
  output logic                              byte_rdy,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overflow,
  output logic                              break_det
);

  localparam logic [ACC_W-1:0] INC =
    ACC_W'(calc_inc(64'(BAUD), 64'(CLK_FREQ), ACC_W));

  // Synchronizer, edge detector and NCO
  logic             sync1_q, rxs_q, rxs_prev_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick;

  // Frame state
  rx_state_e            state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d, os_nxt;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;

  logic                 vote_tick, vote, par_en, par_exp, stop_ferr;
  logic                 push, brk;
  logic [DATA_BITS+1:0] push_data;

  // Carry out of the free-running accumulator is the 16x oversample tick
  assign {tick, acc_d} = {1'b0, acc_q} + {1'b0, INC};

  // Two-flop input synchronizer, edge-detect history and NCO accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      acc_q      <= '0;
    end else begin
      sync1_q    <= rx_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      acc_q      <= acc_d;
    end
  end

  assign os_nxt    = os_cnt_q + 4'd1;
  assign vote_tick = tick && (os_nxt == 4'd9);
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign par_en    = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);
  assign par_exp   = (^shift_q) ^ (par_mode_q == PAR_ODD);
  assign stop_ferr = ferr_q | ~vote;
  assign push_data = {perr_q, stop_ferr, shift_q};

  // Receive FSM: next state, bit timing, shifting and push strobe
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_mode_d = par_mode_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    push       = 1'b0;
    brk        = 1'b0;

    if (state_q != IDLE && tick) os_cnt_d = os_nxt;
    if (tick && os_nxt == 4'd7)  samp_d[0] = rxs_q;
    if (tick && os_nxt == 4'd8)  samp_d[1] = rxs_q;

    unique case (state_q)
      IDLE: begin
        par_mode_d = cfg_parity;
        if (rx_enable && rxs_prev_q && !rxs_q) begin
          state_d   = START;
          os_cnt_d  = 4'd0;
          bit_cnt_d = 4'd0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          zero_d    = 1'b1;
        end
      end
      START: begin
        if (vote_tick) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (vote_tick) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~vote;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = 4'd0;
            state_d   = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (vote_tick) begin
          perr_d  = (vote != par_exp);
          zero_d  = zero_q & ~vote;
          state_d = STOP;
        end
      end
      STOP: begin
        if (vote_tick) begin
          ferr_d = stop_ferr;
          zero_d = zero_q & ~vote;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            push    = 1'b1;
            brk     = zero_q & ~vote;
            state_d = stop_ferr ? WAIT_HIGH : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver abandons any frame in progress without a push
    if (!rx_enable && state_q != IDLE) begin
      state_d = IDLE;
      push    = 1'b0;
      brk     = 1'b0;
    end
  end

  // Frame state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      os_cnt_q   <= 4'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      par_mode_q <= PAR_NONE;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_mode_q <= par_mode_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
    end
  end

  assign break_det = brk;
  assign byte_rdy  = ~empty;

  uart3_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (push),
    .wdata_i    (push_data),
    .pop_i      (rd_en),
    .clr_ovf_i  (clr_overflow),
    .rdata_o    (rd_data),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_uart3_rx.sv
// Self-checking bench for uart3_rx. Instance 0 is 8-bit / 1 stop / 4-deep,
// instance 1 is 9-bit / 2 stop / 16-deep. A queue-based model predicts every
// FIFO entry from the serial frames the bench transmits.
`timescale 1ns/1ps
module tb_uart3_rx;

  localparam real BIT_NS = 1.0e9 / 460800.0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] rx  = 2'b11;
  logic [1:0] rd  = 2'b00;
  logic [1:0] clr = 2'b00;
  logic [1:0] par_a = 2'd0, par_b = 2'd0;

  logic [9:0]  rdat_a;
  logic [10:0] rdat_b;
  logic [2:0]  cnt_a;
  logic [4:0]  cnt_b;
  logic [1:0]  rdy, emp, ful, ovf, brk_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [1:0]  m_ovf = 2'b00;
  int          exp_brk [2] = '{0, 0};
  int          seen_brk[2] = '{0, 0};

  always #12.5 clk = ~clk;

  uart3_rx #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx_enable(en), .rx_in(rx[0]), .cfg_parity(par_a),
    .rd_en(rd[0]), .clr_overflow(clr[0]), .rd_data(rdat_a), .byte_rdy(rdy[0]),
    .empty(emp[0]), .full(ful[0]), .count(cnt_a), .overflow(ovf[0]),
    .break_det(brk_o[0])
  );

  uart3_rx #(.DATA_BITS(9), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .rx_enable(en), .rx_in(rx[1]), .cfg_parity(par_b),
    .rd_en(rd[1]), .clr_overflow(clr[1]), .rd_data(rdat_b), .byte_rdy(rdy[1]),
    .empty(emp[1]), .full(ful[1]), .count(cnt_b), .overflow(ovf[1]),
    .break_det(brk_o[1])
  );

  // Count break pulses; each is high for exactly one clk
  always @(negedge clk) begin
    if (brk_o[0]) seen_brk[0]++;
    if (brk_o[1]) seen_brk[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs_head(input int i);
    if (i == 0) return 16'(rdat_a);
    return 16'(rdat_b);
  endfunction

  function automatic int obs_cnt(input int i);
    if (i == 0) return int'(cnt_a);
    return int'(cnt_b);
  endfunction

  function automatic int msize(input int i);
    if (i == 0) return q_a.size();
    return q_b.size();
  endfunction

  function automatic int mdepth(input int i);
    return (i == 0) ? 4 : 16;
  endfunction

  // Serial transmitter: start, data LSB first, optional parity, stop bits, idle
  task automatic tx_raw(input int i, input logic [8:0] data, input logic [1:0] mode,
                        input logic par_bit, input logic stop_zero, input real scale);
    int  nb;
    int  ns;
    real bt;
    nb = (i == 0) ? 8 : 9;
    ns = (i == 0) ? 1 : 2;
    bt = BIT_NS * scale;
    rx[i] = 1'b0;
    #(bt);
    for (int k = 0; k < nb; k++) begin
      rx[i] = data[k];
      #(bt);
    end
    if (mode == 2'd1 || mode == 2'd2) begin
      rx[i] = par_bit;
      #(bt);
    end
    for (int k = 0; k < ns; k++) begin
      rx[i] = ~stop_zero;
      #(bt);
    end
    rx[i] = 1'b1;
    #(2.0 * bt);
  endtask

  // Model: store an entry unless the FIFO is full, in which case flag overflow
  task automatic model_push(input int i, input logic [15:0] e);
    if (msize(i) < mdepth(i)) begin
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end else begin
      m_ovf[i] = 1'b1;
    end
  endtask

  // Transmit one frame and predict the entry it produces
  task automatic tx_frame(input int i, input logic [8:0] data, input logic [1:0] mode,
                          input logic par_bit, input logic stop_zero, input real scale);
    int          nb;
    int          ones;
    bit          pen;
    bit          p_err;
    logic [15:0] e;
    nb = (i == 0) ? 8 : 9;
    if (i == 0) par_a = mode;
    else        par_b = mode;
    tx_raw(i, data, mode, par_bit, stop_zero, scale);
    pen  = (mode == 2'd1 || mode == 2'd2);
    ones = 0;
    e    = '0;
    for (int k = 0; k < nb; k++) begin
      ones += int'(data[k]);
      e[k] = data[k];
    end
    // Odd mode wants an odd total of ones (data + parity), even mode an even total
    p_err = pen && ((((ones + int'(par_bit)) % 2) == 1) != (mode == 2'd1));
    e[nb]     = stop_zero;
    e[nb + 1] = p_err;
    if (stop_zero && ones == 0 && (!pen || !par_bit)) exp_brk[i]++;
    model_push(i, e);
  endtask

  task automatic check_status(input int i, input string tag);
    @(negedge clk);
    check({tag, "_count"},    obs_cnt(i), msize(i));
    check({tag, "_empty"},    emp[i], msize(i) == 0);
    check({tag, "_full"},     ful[i], msize(i) == mdepth(i));
    check({tag, "_byte_rdy"}, rdy[i], msize(i) != 0);
    check({tag, "_overflow"}, ovf[i], m_ovf[i]);
    check({tag, "_breaks"},   seen_brk[i], exp_brk[i]);
    if (msize(i) > 0) begin
      if (i == 0) check({tag, "_head"}, obs_head(i), q_a[0]);
      else        check({tag, "_head"}, obs_head(i), q_b[0]);
    end
  endtask

  // Pop every modelled entry, checking each head, then try a read while empty
  task automatic drain(input int i, input string tag);
    logic [15:0] e;
    int          n;
    n = msize(i);
    for (int k = 0; k < n; k++) begin
      if (i == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      @(negedge clk);
      check({tag, "_pop_data"}, obs_head(i), e);
      rd[i] = 1'b1;
      @(negedge clk);
      rd[i] = 1'b0;
    end
    @(negedge clk);
    rd[i] = 1'b1;
    @(negedge clk);
    rd[i] = 1'b0;
    @(negedge clk);
    check({tag, "_drained_count"}, obs_cnt(i), 0);
    check({tag, "_drained_empty"}, emp[i], 1'b1);
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_count",    obs_cnt(i), 0);
    check("rst_empty",    emp[i], 1'b1);
    check("rst_full",     ful[i], 1'b0);
    check("rst_byte_rdy", rdy[i], 1'b0);
    check("rst_overflow", ovf[i], 1'b0);
    check("rst_break",    brk_o[i], 1'b0);
    check("rst_rd_data",  obs_head(i), 16'h0);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b1;
    en  = 1'b1;
    #(2.0 * BIT_NS);

    // Plain 8N1 byte, then one unload pulse
    tx_frame(0, 9'h0A5, 2'd0, 1'b0, 1'b0, 1.0);
    check_status(0, "a5");
    drain(0, "a5");

    // Even parity: wrong then right parity bit
    tx_frame(0, 9'h03C, 2'd2, 1'b1, 1'b0, 1.0);
    check_status(0, "par_bad");
    drain(0, "par_bad");
    tx_frame(0, 9'h03C, 2'd2, 1'b0, 1'b0, 1.0);
    check_status(0, "par_ok");
    drain(0, "par_ok");
    par_a = 2'd0;

    // Short low glitch must be rejected; the following byte still lands
    rx[0] = 1'b0;
    #870;
    rx[0] = 1'b1;
    #(3.0 * BIT_NS);
    check_status(0, "glitch");
    tx_frame(0, 9'h012, 2'd0, 1'b0, 1'b0, 1.0);
    check_status(0, "after_glitch");
    drain(0, "after_glitch");

    // Overflow on the 4-deep FIFO, then clear it
    for (int k = 1; k <= 5; k++) tx_frame(0, 9'(k), 2'd0, 1'b0, 1'b0, 1.0);
    check_status(0, "ovf");
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    m_ovf[0] = 1'b0;
    check_status(0, "ovf_clr");
    drain(0, "ovf");

    // Break: line low for two frame times
    rx[0] = 1'b0;
    #(20.0 * BIT_NS);
    rx[0] = 1'b1;
    #(2.0 * BIT_NS);
    exp_brk[0]++;
    model_push(0, 16'h0100);
    check_status(0, "break");
    drain(0, "break");

    // Receiver disabled mid-frame: nothing stored
    fork
      tx_raw(0, 9'h0C3, 2'd0, 1'b0, 1'b0, 1.0);
      begin
        #(3.5 * BIT_NS);
        en = 1'b0;
      end
    join
    en = 1'b1;
    #(BIT_NS);
    check_status(0, "abort");

    // Random 8-bit traffic with random parity modes and framing errors
    for (int k = 0; k < 12; k++) begin
      tx_frame(0, 9'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1.0);
      check_status(0, "rand_a");
      if (msize(0) >= 3 || $urandom_range(0, 1) == 1) drain(0, "rand_a");
    end
    drain(0, "rand_a_end");
    par_a = 2'd0;

    // 9-bit, 2 stop bits across a +/-3% baud sweep
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) begin
        tx_frame(1, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, 0.97 + 0.03 * real'(s));
        check_status(1, "sweep");
      end
      drain(1, "sweep");
    end
    par_b = 2'd0;

    // Reset in the middle of a data field with entries pending
    tx_frame(0, 9'h011, 2'd0, 1'b0, 1'b0, 1.0);
    tx_frame(0, 9'h022, 2'd0, 1'b0, 1'b0, 1.0);
    tx_frame(1, 9'h133, 2'd0, 1'b0, 1'b0, 1.0);
    check_status(0, "pre_rst");
    fork
      tx_raw(0, 9'h05A, 2'd0, 1'b0, 1'b0, 1.0);
      begin
        #(4.5 * BIT_NS);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
      end
    join
    q_a.delete();
    q_b.delete();
    m_ovf = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #(BIT_NS);
    tx_frame(0, 9'h07E, 2'd0, 1'b0, 1'b0, 1.0);
    check_status(0, "post_rst");
    drain(0, "post_rst");
    check_status(1, "post_rst_b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart3_rx.md
Name: uart3_rx

Overview:
- Next-generation UART receiver replacing uart2_rx on the FONT5 serial command path.
- Uses a 16x oversampled, NCO-generated bit clock, so non-integer CLK_FREQ/BAUD ratios stay accurate.
- Adds 3-sample majority voting, configurable frame (data bits, parity, stop bits), error tagging and break detection.
- Buffers received characters in an internal first-word-fall-through FIFO, drained by uart_unload or a register interface.

Parameters:
- DATA_BITS, 8: data bits per character, legal range 5..9.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- BAUD, 460800: line rate in baud.
- CLK_FREQ, 40000000: clk frequency in Hz.
- ACC_W, 16: NCO accumulator width. Increment INC = round(BAUD*16*2^ACC_W/CLK_FREQ); 12080 at the defaults.
- FIFO_DEPTH, 16: number of FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_enable  in  1  receiver enable.
- rx_in  in  1  serial input, asynchronous to clk, idles high.
- cfg_parity  in  2  parity mode: 0 none, 1 odd, 2 even, 3 treated as none. Sampled only in IDLE.
- rd_en  in  1  pop the FIFO head.
- clr_overflow  in  1  clears the overflow flag.
- rd_data  out  DATA_BITS+2  FIFO head, packed as {perr, ferr, data}.
- byte_rdy  out  1  equals !empty; drop-in compatible with uart_unload.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky; set when a character is lost.
- break_det  out  1  one-cycle pulse when a break is detected.

Behaviour:
- Reset values: rx synchronizer = 1, accumulator = 0, state = IDLE, FIFO empty, count = 0, empty = 1, full = 0, overflow = 0, break_det = 0, rd_data = 0.
- Input synchronizer: rx_in passes through 2 flops. All decisions use the synchronized value rxs.
- Oversample tick:
  - Each clk, acc <= acc + INC (ACC_W-bit wrap).
  - tick is the carry out of that add.
  - acc runs freely and is never reset mid-frame.
- Bit timing: os_cnt (4 bits) increments on each tick inside a frame and wraps 15 -> 0 at every bit boundary.
- Majority vote: rxs is sampled on ticks with os_cnt = 7, 8 and 9. The bit value is the majority of the 3 samples, decided on the os_cnt = 9 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a high-to-low transition on rxs with rx_enable = 1 -> START; os_cnt cleared to 0.
  - START: a vote of 1 is a glitch -> IDLE, nothing pushed. A vote of 0 -> DATA.
  - DATA: bits are shifted in LSB first. After DATA_BITS votes -> PARITY if parity is enabled, else STOP.
  - PARITY: perr = 1 when the vote mismatches the selected odd/even parity over the data bits.
  - STOP: after STOP_BITS votes; ferr = 1 if any stop vote is 0.
  - STOP push point: the character is pushed on the os_cnt = 9 tick of the last stop bit. This gives half-bit resync margin for the next start bit.
  - STOP exit: -> WAIT_HIGH if ferr, else IDLE.
  - WAIT_HIGH: remain until rxs = 1, then -> IDLE.
- Break: all data votes 0, parity vote 0 (if enabled) and stop vote 0.
  - break_det pulses for 1 cycle, coincident with the push.
  - The character (data 0, ferr = 1) is still stored.
- rx_enable = 0 mid-frame: abort to IDLE on the next clk; no push, no flags.
- FIFO:
  - Push when push = 1 and !full. count and flags update on the next clk.
  - rd_data shows the head whenever !empty.
  - rd_en while empty is ignored.
  - Push and rd_en in the same cycle with full = 1: both are accepted and count is unchanged.
  - Push and rd_en in the same cycle with empty = 1: the push is accepted and the read is ignored.
  - Pointers use $clog2(FIFO_DEPTH) bits and wrap naturally.
- Overflow: push while full, without a simultaneous rd_en, drops the new character and sets overflow. clr_overflow clears it; if set and clear coincide, set wins.
- Latency: empty falls 1 clk after the push tick, about 9.5 bit times after the start edge plus 2 synchronizer clks.
- Asserting rst at any time returns every output to its reset value immediately.

Decomposition:
- Package uart3_pkg holds:
  - Parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encodings.
  - The INC computation as a constant function.
- Sub-module uart3_rx_fifo: synchronous FWFT FIFO parameterised by width and depth, with count, full, empty and push/pop rules exactly as above.
- The FSM, NCO and voter stay in uart3_rx.

Test Plan:
- 40 MHz clk, 460.8 kBaud, 8N1, byte 0xA5 -> rd_data = {0,0,0xA5}, byte_rdy = 1. One uart_unload pulse empties the FIFO.
- cfg_parity = even, send 0x3C with parity bit 1 -> perr = 1, ferr = 0, data 0x3C. Repeat with parity bit 0 -> perr = 0.
- 1-bit-time-minus-60% low glitch on an idle line (about 870 ns) -> nothing pushed, FSM back in IDLE, next byte 0x12 received correctly.
- FIFO_DEPTH = 4, send 5 bytes 0x01..0x05 with no reads:
  - -> full = 1, overflow = 1, FIFO holds 0x01..0x04.
  - clr_overflow -> overflow = 0.
- Line held low for 2 frame times -> one break_det pulse, entry {0,1,0x00}, no further pushes until the line returns high.
- Baud sweep at ±3% with 9-bit data and 2 stop bits -> all bytes correct.
- Reset asserted mid-DATA -> all outputs at reset values; the following clean byte 0x7E is received intact.
